irq_dispatcher: RTL and testbench
=================================

Name: irq_dispatcher

Overview:
Peripheral-side interrupt source for the core. It collects edge-triggered requests from up to NSRC peripherals and arbitrates them by fixed priority. It then issues a one-cycle pulse on the core's irq1/irq2/irq3 line for the winning source's class and tracks the core's eirq handshake, so only one interrupt is in flight at a time. The winning source ID is presented as a 16-bit vector for the core's in1/in2 input path.

Parameters:
NSRC, 8, number of peripheral request lines (1..16); index 0 has the highest priority.
CLS_MAP, 16'hFDA5, 2 bits per source (bits [2i+1:2i]): 1 = irq1, 2 = irq2, 3 = irq3; value 0 is treated as 3.
TIMEOUT, 255, cycles to wait for eirq after a pulse before re-arbitrating (1..65535).

Ports:
clk  in  1  system clock (same as the core)
rst  in  1  asynchronous, active-low reset
src_req  in  NSRC  peripheral request levels, sampled for rising edges
mask  in  NSRC  1 = source enabled for arbitration
prst  in  1  core program reset (core prst output); synchronous soft clear
eirq  in  1  core "in interrupt" flag (core eirq output)
clr_ovr  in  1  one-cycle pulse; clears overrun
irq1  out  1  to core irq1
irq2  out  1  to core irq2
irq3  out  1  to core irq3
vec  out  16  {zeros, cur_id}; ID of the last dispatched source
pending  out  NSRC  latched, not-yet-accepted requests
overrun  out  NSRC  sticky; an edge arrived while that source was already pending
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; pending, overrun, vec, the edge-detect history, timeout counter and irq1..3 all go to 0.
- Edge detect: a registered copy of src_req is kept. rise[i] = src_req[i] & ~prev[i]. A rise sets pending[i] on the next edge. If pending[i] is already 1 when a rise occurs, overrun[i] is set. If a set and a clear of pending[i] happen in the same cycle, the set wins (the bit stays 1).
- Arbitration: candidates = pending & mask. The winner is the lowest set index. Masked pending bits are held but ignored.
- FSM:
  - IDLE: if candidates != 0, latch cur_id = winner and update vec in the same edge; go to PULSE.
  - PULSE (1 cycle): the irqN line selected by CLS_MAP[cur_id] is 1 and the others are 0; clear the counter; go to WAIT_ACK.
  - WAIT_ACK: if eirq=1, clear pending[cur_id] and go to SERVICE. Otherwise increment the counter; when counter == TIMEOUT-1, go to IDLE and keep pending[cur_id] so it is retried.
  - SERVICE: stay while eirq=1; on eirq=0 go to IDLE. A minimum of one IDLE cycle occurs between dispatches.
- irq outputs are registered: the pulse is exactly 1 cycle wide and appears the cycle after the IDLE decision. Latency from the src_req rise to the irq pulse is 3 clocks (edge register, pending, IDLE→PULSE).
- eirq already high when PULSE begins: accepted at the first WAIT_ACK cycle.
- Masking cur_id while in WAIT_ACK has no effect on the in-flight dispatch.
- prst=1 (synchronous, priority over everything except rst): clear pending and overrun, go to IDLE, drive irq1..3 low. vec is preserved and prev is still updated.
- clr_ovr: clears all overrun bits. A new overrun set in the same cycle wins.
- CLS_MAP entries for indices ≥ NSRC are ignored.

Test Plan:
- Reset: with rst=0 held for 3 cycles and then released, irq1..3=0, vec=0, pending=0, busy=0. Assert rst mid-WAIT_ACK → everything returns to 0 asynchronously.
- Single request: src_req[2] rises at cycle 0 → pending[2]=1 at cycle 2 and irq2 pulses for 1 cycle at cycle 3 with vec=2. eirq=1 at cycle 5 → pending[2]=0 and state SERVICE. eirq=0 at cycle 9 → busy=0 at cycle 10.
- Priority and mask: src_req[5] and src_req[1] rise in the same cycle → irq1 (source 1) dispatches first, then irq3 (source 5) after the service. With mask[1]=0, source 5 dispatches first and pending[1] stays 1.
- Timeout: TIMEOUT=4, source 0 requested, eirq never asserted → irq1 pulses, then returns to IDLE after 4 cycles and re-pulses. pending[0] remains 1 throughout.
- Overrun and simultaneity: a second rise on src_req[3] while pending[3]=1 → overrun[3]=1. A rise on src_req[3] in the same cycle that eirq accepts source 3 → pending[3] stays 1. clr_ovr → overrun=0.
- prst: assert prst in SERVICE with pending=8'h24 → pending=0, overrun=0, state IDLE, no irq pulse, vec unchanged.

Source files
------------

// File: rtl/irq_dispatcher.sv
// Fixed-priority interrupt dispatcher: latches edge requests and pulses the core's irq1..3 lines.
// Tracks the eirq handshake so only one dispatch is in flight at a time.
module irq_dispatcher #(
  parameter int unsigned NSRC    = 8,
  parameter logic [31:0] CLS_MAP = 32'h0000_FDA5,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_req,
  input  logic [NSRC-1:0] mask,
  input  logic            prst,
  input  logic            eirq,
  input  logic            clr_ovr,
  output logic            irq1,
  output logic            irq2,
  output logic            irq3,
  output logic [15:0]     vec,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] overrun,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StPulse, StWaitAck, StService} state_e;

  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [NSRC-1:0] src_q, prev_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] ovr_q, ovr_d;
  logic [NSRC-1:0] rise, cand;
  logic [3:0]      cur_id_q, cur_id_d, win_id;
  logic [2:0]      irq_q, irq_d;
  logic [15:0]     cnt_q, cnt_d;

  // Class code 0 is treated the same as 3.
  function automatic logic [2:0] cls_onehot(input logic [3:0] id);
    logic [1:0] c;
    c = CLS_MAP[{id, 1'b0} +: 2];
    case (c)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  assign rise = src_q & ~prev_q;
  assign cand = pend_q & mask;

  always_comb begin
    win_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) win_id = 4'(i);
    end
  end

  // A new rise beats the acceptance clear of the same bit.
  always_comb begin
    pend_d = pend_q;
    ovr_d  = clr_ovr ? '0 : ovr_q;
    if (state_q == StWaitAck && eirq) begin
      for (int i = 0; i < NSRC; i++) begin
        if (cur_id_q == 4'(i)) pend_d[i] = 1'b0;
      end
    end
    pend_d = pend_d | rise;
    ovr_d  = ovr_d | (rise & pend_q);
    if (prst) begin
      pend_d = '0;
      ovr_d  = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    irq_d    = '0;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|cand) begin
          cur_id_d = win_id;
          irq_d    = cls_onehot(win_id);
          state_d  = StPulse;
        end
      end
      StPulse: begin
        cnt_d   = '0;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (eirq) begin
          state_d = StService;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StService: begin
        if (!eirq) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (prst) begin
      state_d  = StIdle;
      irq_d    = '0;
      cur_id_d = cur_id_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      src_q    <= '0;
      prev_q   <= '0;
      pend_q   <= '0;
      ovr_q    <= '0;
      cur_id_q <= '0;
      irq_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_req;
      prev_q   <= src_q;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      cur_id_q <= cur_id_d;
      irq_q    <= irq_d;
      cnt_q    <= cnt_d;
    end
  end

  assign irq1    = irq_q[0];
  assign irq2    = irq_q[1];
  assign irq3    = irq_q[2];
  assign vec     = {12'b0, cur_id_q};
  assign pending = pend_q;
  assign overrun = ovr_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_irq_dispatcher.sv
// Bench for irq_dispatcher: expected dispatches queued at stimulus time, checked on each irq pulse.
module tb_irq_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  src_req = '0;
  logic [7:0]  mask = 8'hFF;
  logic        prst = 1'b0;
  logic        eirq = 1'b0;
  logic        clr_ovr = 1'b0;
  logic        irq1, irq2, irq3;
  logic [15:0] vec;
  logic [7:0]  pending, overrun;
  logic        busy;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  logic prev_any = 1'b0;

  irq_dispatcher #(
    .TIMEOUT(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .src_req (src_req),
    .mask    (mask),
    .prst    (prst),
    .eirq    (eirq),
    .clr_ovr (clr_ovr),
    .irq1    (irq1),
    .irq2    (irq2),
    .irq3    (irq3),
    .vec     (vec),
    .pending (pending),
    .overrun (overrun),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Class table for the default map 16'hFDA5.
  function automatic int exp_cls(input int id);
    case (id)
      0, 1, 4: return 1;
      2, 3:    return 2;
      default: return 3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_irq();
    int n = 0;
    while (!(irq1 | irq2 | irq3) && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("wait_irq", 32'd0, 32'd1);
  endtask

  task automatic serve();
    int n = 0;
    wait_irq();
    tick();
    eirq = 1'b1;
    tick();
    tick();
    eirq = 1'b0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("wait_idle", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin : mon
    int cls;
    int id;
    if (rst && (irq1 | irq2 | irq3)) begin
      check("irq_onehot", 32'(irq1) + 32'(irq2) + 32'(irq3), 32'd1);
      check("pulse_width", {31'b0, prev_any}, 32'd0);
      cls = irq1 ? 1 : (irq2 ? 2 : 3);
      if (exp_q.size() == 0) begin
        check("sb_unexpected_irq", {16'b0, vec}, 32'hFFFF);
      end else begin
        id = exp_q.pop_front();
        check("sb_vec", {16'b0, vec}, id);
        check("sb_class", cls, exp_cls(id));
      end
    end
    prev_any = rst & (irq1 | irq2 | irq3);
  end

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    tick();
    check("rst_irq", {29'b0, irq3, irq2, irq1}, 0);
    check("rst_vec", {16'b0, vec}, 0);
    check("rst_pending", {24'b0, pending}, 0);
    check("rst_busy", {31'b0, busy}, 0);

    // Single request on source 2
    src_req = 8'h04;
    exp_q.push_back(2);
    tick();
    tick();
    check("t1_pending_c2", {24'b0, pending}, 32'h04);
    check("t1_busy_c2", {31'b0, busy}, 0);
    check("t1_irq2_c2", {31'b0, irq2}, 0);
    tick();
    check("t1_irq2_c3", {31'b0, irq2}, 1);
    check("t1_vec_c3", {16'b0, vec}, 2);
    tick();
    check("t1_irq2_c4", {31'b0, irq2}, 0);
    tick();
    eirq = 1'b1;
    tick();
    check("t1_pending_c6", {24'b0, pending}, 0);
    check("t1_busy_c6", {31'b0, busy}, 1);
    src_req = 8'h00;
    tick();
    tick();
    tick();
    eirq = 1'b0;
    tick();
    check("t1_busy_c10", {31'b0, busy}, 0);

    // Priority: sources 1 and 5 together
    src_req = 8'h22;
    exp_q.push_back(1);
    exp_q.push_back(5);
    serve();
    check("t2_pending_after1", {24'b0, pending}, 32'h20);
    serve();
    check("t2_pending_after5", {24'b0, pending}, 0);

    // Source 1 masked: 5 goes first, 1 held
    src_req = 8'h00;
    tick();
    tick();
    mask = 8'hFD;
    src_req = 8'h22;
    exp_q.push_back(5);
    serve();
    check("t2_masked_pending", {24'b0, pending}, 32'h02);
    tick();
    tick();
    tick();
    check("t2_masked_idle", {31'b0, busy}, 0);
    mask = 8'hFF;
    exp_q.push_back(1);
    serve();
    check("t2_unmask_pending", {24'b0, pending}, 0);

    // Timeout with TIMEOUT=4: source 0 is retried
    src_req = 8'h00;
    tick();
    tick();
    src_req = 8'h01;
    exp_q.push_back(0);
    exp_q.push_back(0);
    tick();
    tick();
    tick();
    check("t3_irq1_first", {31'b0, irq1}, 1);
    for (int k = 4; k <= 7; k++) begin
      tick();
      check("t3_wait_busy", {31'b0, busy}, 1);
      check("t3_wait_pending", {24'b0, pending}, 32'h01);
      check("t3_wait_irq1", {31'b0, irq1}, 0);
    end
    tick();
    check("t3_idle_busy", {31'b0, busy}, 0);
    check("t3_idle_pending", {24'b0, pending}, 32'h01);
    tick();
    check("t3_irq1_retry", {31'b0, irq1}, 1);
    tick();
    eirq = 1'b1;
    tick();
    check("t3_accept_pending", {24'b0, pending}, 0);
    eirq = 1'b0;
    tick();
    check("t3_done_busy", {31'b0, busy}, 0);
    src_req = 8'h00;
    tick();
    tick();

    // Overrun and rise coinciding with acceptance on source 3
    src_req = 8'h08;
    exp_q.push_back(3);
    tick();
    src_req = 8'h00;
    tick();
    check("t4_pending_c2", {24'b0, pending}, 32'h08);
    src_req = 8'h08;
    tick();
    check("t4_irq2_c3", {31'b0, irq2}, 1);
    src_req = 8'h00;
    tick();
    check("t4_overrun", {24'b0, overrun}, 32'h08);
    src_req = 8'h08;
    exp_q.push_back(3);
    tick();
    eirq = 1'b1;
    tick();
    check("t4_set_wins", {24'b0, pending}, 32'h08);
    check("t4_service", {31'b0, busy}, 1);
    eirq = 1'b0;
    src_req = 8'h00;
    tick();
    check("t4_idle", {31'b0, busy}, 0);
    serve();
    check("t4_pending_done", {24'b0, pending}, 0);
    check("t4_overrun_sticky", {24'b0, overrun}, 32'h08);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("t4_clr_ovr", {24'b0, overrun}, 0);

    // prst in SERVICE with pending=8'h24
    src_req = 8'h24;
    exp_q.push_back(2);
    wait_irq();
    tick();
    eirq = 1'b1;
    src_req = 8'h20;
    tick();
    check("t5_pending_svc", {24'b0, pending}, 32'h20);
    src_req = 8'h24;
    tick();
    tick();
    check("t5_pending_24", {24'b0, pending}, 32'h24);
    check("t5_busy", {31'b0, busy}, 1);
    prst = 1'b1;
    tick();
    check("t5_prst_pending", {24'b0, pending}, 0);
    check("t5_prst_overrun", {24'b0, overrun}, 0);
    check("t5_prst_busy", {31'b0, busy}, 0);
    check("t5_prst_vec", {16'b0, vec}, 2);
    check("t5_prst_irq", {29'b0, irq3, irq2, irq1}, 0);
    prst = 1'b0;
    eirq = 1'b0;
    repeat (4) tick();
    check("t5_stay_idle", {31'b0, busy}, 0);

    // Asynchronous reset during WAIT_ACK
    src_req = 8'h00;
    tick();
    src_req = 8'h80;
    exp_q.push_back(7);
    wait_irq();
    tick();
    check("t6_waitack_busy", {31'b0, busy}, 1);
    src_req = 8'h00;
    #1 rst = 1'b0;
    #1;
    check("t6_rst_busy", {31'b0, busy}, 0);
    check("t6_rst_vec", {16'b0, vec}, 0);
    check("t6_rst_pending", {24'b0, pending}, 0);
    check("t6_rst_irq", {29'b0, irq3, irq2, irq1}, 0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("t6_after_busy", {31'b0, busy}, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
